// File: rtl/loop_trace_capture.sv
// Change-event trace capture: records loop-generator value changes into an 8-entry FIFO.
// Optional sequence checker on act2 enabled by defining LOOP_TRACE_CHECK_EN.
module loop_trace_capture #(
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cap_en,
    input  logic                  clr,
    input  logic [DATA_W-1:0]     act1,
    input  logic [DATA_W-1:0]     act2,
    input  logic [3:0]            phase,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*DATA_W+1:0]   out_data,
    output logic                  ovf,
    output logic [7:0]            drop_cnt,
    output logic [7:0]            frame_cnt,
    output logic                  err
);

    localparam int ENT_W = 2*DATA_W + 2;

    logic [DATA_W-1:0] prev1_q, prev2_q;
    logic              phase1_q;
    logic [ENT_W-1:0]  mem_q [8];
    logic [2:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [3:0]        count_q, count_d;
    logic              ovf_q, ovf_d;
    logic [7:0]        drop_cnt_q, drop_cnt_d;
    logic [7:0]        frame_cnt_q, frame_cnt_d;

    logic chg1, chg2, change_evt, fifo_full, fifo_empty, push, pop, drop;
    logic [ENT_W-1:0] entry;

    assign chg1       = (act1 != prev1_q);
    assign chg2       = (act2 != prev2_q);
    // The step after an end-of-frame marker is the generator clearing its values, not a real change.
    assign change_evt = cap_en && (chg1 || chg2) && !phase1_q;
    assign entry      = {chg2, chg1, act2, act1};

    assign fifo_full  = (count_q == 4'd8);
    assign fifo_empty = (count_q == 4'd0);
    assign pop        = !fifo_empty && out_ready;
    assign push       = change_evt && (!fifo_full || pop);
    assign drop       = change_evt && fifo_full && !pop;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        ovf_d       = ovf_q;
        drop_cnt_d  = drop_cnt_q;
        frame_cnt_d = frame_cnt_q;
        if (clr) begin
            wr_ptr_d    = 3'd0;
            rd_ptr_d    = 3'd0;
            count_d     = 4'd0;
            ovf_d       = 1'b0;
            drop_cnt_d  = 8'd0;
            frame_cnt_d = 8'd0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 3'd1;
            if (pop)  rd_ptr_d = rd_ptr_q + 3'd1;
            case ({push, pop})
                2'b10:   count_d = count_q + 4'd1;
                2'b01:   count_d = count_q - 4'd1;
                default: count_d = count_q;
            endcase
            if (drop) begin
                ovf_d = 1'b1;
                if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
            end
            if (cap_en && (phase == 4'd1)) frame_cnt_d = frame_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev1_q     <= '0;
            prev2_q     <= '0;
            phase1_q    <= 1'b0;
            wr_ptr_q    <= 3'd0;
            rd_ptr_q    <= 3'd0;
            count_q     <= 4'd0;
            ovf_q       <= 1'b0;
            drop_cnt_q  <= 8'd0;
            frame_cnt_q <= 8'd0;
        end else begin
            prev1_q     <= act1;
            prev2_q     <= act2;
            phase1_q    <= (phase == 4'd1);
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            drop_cnt_q  <= drop_cnt_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Storage is data only; validity is tracked entirely by the pointers and occupancy.
    always_ff @(posedge clk) begin
        if (push && !clr) mem_q[wr_ptr_q] <= entry;
    end

    assign out_valid = !fifo_empty;
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
    assign ovf       = ovf_q;
    assign drop_cnt  = drop_cnt_q;
    assign frame_cnt = frame_cnt_q;

`ifdef LOOP_TRACE_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (clr)
            err_d = 1'b0;
        else if (change_evt && (act2 != prev2_q + 8'd1))
            err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_loop_trace_capture.sv
// Scoreboard bench for loop_trace_capture: stimulus pushes expected entries, a monitor pops on accept.
module tb_loop_trace_capture;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cap_en = 1'b0;
    logic        clr = 1'b0;
    logic [7:0]  act1 = 8'd0;
    logic [7:0]  act2 = 8'd0;
    logic [3:0]  phase = 4'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [17:0] out_data;
    logic        ovf;
    logic [7:0]  drop_cnt;
    logic [7:0]  frame_cnt;
    logic        err;

    int n_cmp = 0;
    int n_mis = 0;
    logic [17:0] exp_q [$];

    loop_trace_capture dut (
        .clk(clk), .rst_n(rst_n), .cap_en(cap_en), .clr(clr),
        .act1(act1), .act2(act2), .phase(phase),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .ovf(ovf), .drop_cnt(drop_cnt), .frame_cnt(frame_cnt), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: an accepted head is compared against the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n && !clr && out_valid && out_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_mis++;
                $display("FAIL fifo_head: got %h, expected no entry", out_data);
            end else begin
                logic [17:0] e;
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    n_mis++;
                    $display("FAIL fifo_head: got %h, expected %h", out_data, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        step(3);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data",  32'(out_data), 0);
        chk("rst_ovf",       32'(ovf), 0);
        chk("rst_drop_cnt",  32'(drop_cnt), 0);
        chk("rst_frame_cnt", 32'(frame_cnt), 0);
        chk("rst_err",       32'(err), 0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        cap_en = 1'b1;

        // Scenario 1: act2 0->1, entry visible the cycle after the write edge
        step(4);
        act2 = 8'h01;
        exp_q.push_back(18'h2_01_00);
        step();
        chk("s1_latency_valid", 32'(out_valid), 1);
        step(3);
        chk("s1_drained", 32'(out_valid), 0);

        // Scenario 2: both values change together
        cap_en = 1'b0; act2 = 8'h00;
        step();
        cap_en = 1'b1; act1 = 8'h05; act2 = 8'h05;
        exp_q.push_back(18'h3_05_05);
        step();
        chk("s2_valid", 32'(out_valid), 1);
        step(3);

        // Scenario 3: 10 events with the consumer stalled
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            act1 = 8'h11 + 8'(i);
            if (i < 8) exp_q.push_back({2'b01, 8'h05, 8'h11 + 8'(i)});
            step();
        end
        chk("s3_ovf", 32'(ovf), 1);
        chk("s3_drop_cnt", 32'(drop_cnt), 2);
        chk("s3_head_held", 32'(out_data), 32'h1_05_11);

        // Scenario 4: full, pop and write in the same cycle
        out_ready = 1'b1; act1 = 8'h1B;
        exp_q.push_back(18'h1_05_1B);
        step();
        chk("s4_no_drop", 32'(drop_cnt), 2);
        out_ready = 1'b0; act1 = 8'h1C;
        step();
        chk("s4_still_full_drop", 32'(drop_cnt), 3);
        out_ready = 1'b1;
        step(10);
        chk("s4_drained", 32'(out_valid), 0);

        // Scenario 5: end-of-frame marker then clear step
        phase = 4'd1;
        step();
        phase = 4'd0; act1 = 8'h00; act2 = 8'h00;
        step(2);
        chk("s5_frame_cnt", 32'(frame_cnt), 1);
        chk("s5_no_entry", 32'(out_valid), 0);

        // Reset mid-operation discards buffered entries
        out_ready = 1'b0;
        act1 = 8'h30; step();
        act1 = 8'h31; step();
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_frame", 32'(frame_cnt), 0);
        chk("mid_rst_ovf", 32'(ovf), 1'b0);
        act1 = 8'h42;
        step(2);
        rst_n = 1'b1;
        exp_q.push_back(18'h1_00_42);
        step();
        chk("post_rst_capture", 32'(out_valid), 1);
        out_ready = 1'b1;
        step(3);

        // Synchronous clear flushes entries and discards a same-cycle write
        out_ready = 1'b0;
        act1 = 8'h50; step();
        act1 = 8'h51; step();
        clr = 1'b1; act1 = 8'h52;
        step();
        clr = 1'b0;
        chk("clr_valid", 32'(out_valid), 0);
        chk("clr_ovf", 32'(ovf), 0);
        chk("clr_drop", 32'(drop_cnt), 0);
        chk("clr_frame", 32'(frame_cnt), 0);
        chk("clr_err", 32'(err), 0);
        step();
        chk("clr_prev_updated", 32'(out_valid), 0);
        out_ready = 1'b1;

        // Scenario 6: act2 sequence jump 3->5
        cap_en = 1'b0; act1 = 8'h00; act2 = 8'h03;
        step();
        cap_en = 1'b1; act2 = 8'h05;
        exp_q.push_back(18'h2_05_00);
        step();
`ifdef LOOP_TRACE_CHECK_EN
        chk("s6_err_set", 32'(err), 1);
        step(3);
        chk("s6_err_sticky", 32'(err), 1);
        clr = 1'b1; step(); clr = 1'b0;
        chk("s6_err_clr", 32'(err), 0);
        chk("s6_clr_valid", 32'(out_valid), 0);
        chk("s6_clr_drop", 32'(drop_cnt), 0);
        chk("s6_clr_frame", 32'(frame_cnt), 0);
`else
        chk("s6_err_tied", 32'(err), 0);
        step(3);
        chk("s6_err_tied_later", 32'(err), 0);
`endif

        step(3);
        chk("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
